// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to sweep the whole operand.
    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Legal configuration: digit divides width and fits inside it.
    function automatic bit cfg_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into its top bit so
// the caller can form two's-complement overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, LS digit
// first, with start/busy/done handshake and signed-overflow flag.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_check
        $error("serial_addsub: WIDTH must be a multiple of DIGIT and DIGIT <= WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic               last_step;
    logic               accept;
    logic [IDX_W-1:0]   dig_lo;
    logic [DIGIT-1:0]   dig_s;
    logic               dig_co;
    logic               dig_cmsb;

    assign last_step = (cnt == CNT_W'(STEPS - 1));
    // A new operation is taken in IDLE or directly from DONE (back-to-back).
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign dig_lo    = IDX_W'(int'(cnt) * DIGIT);

    // Single shared slice adder, steered to the current digit by the counter.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (op_a[dig_lo +: DIGIT]),
        .b     (op_b[dig_lo +: DIGIT]),
        .ci    (carry),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start during RUN is deliberately not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-digit accumulation and final flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so invert B and force carry-in.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            s[dig_lo +: DIGIT] <= dig_s;
            carry              <= dig_co;
            if (last_step) begin
                cout <= dig_co;
                ovf  <= dig_co ^ dig_cmsb;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases on a 16/4 instance
// plus randomized operations on 16/4, 16/1, 16/16 and 8/2 instances.
module tb_serial_addsub;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy0, done0, cout0, ovf0;
    logic [15:0] s0;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] s1;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] s2;
    logic        busy3, done3, cout3, ovf3;
    logic [7:0]  s3;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0)
    );
    serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
    );
    serial_addsub #(.WIDTH(8), .DIGIT(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy3), .done(done3), .s(s3), .cout(cout3), .ovf(ovf3)
    );

    logic [15:0] s_all    [4];
    logic        cout_all [4];
    logic        ovf_all  [4];
    logic        done_all [4];

    assign s_all[0] = s0;  assign s_all[1] = s1;  assign s_all[2] = s2;  assign s_all[3] = {8'h00, s3};
    assign cout_all[0] = cout0; assign cout_all[1] = cout1; assign cout_all[2] = cout2; assign cout_all[3] = cout3;
    assign ovf_all[0] = ovf0;   assign ovf_all[1] = ovf1;   assign ovf_all[2] = ovf2;   assign ovf_all[3] = ovf3;
    assign done_all[0] = done0; assign done_all[1] = done1; assign done_all[2] = done2; assign done_all[3] = done3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Plain-arithmetic reference: w-bit a + b + cin, or a - b as a + ~b + 1.
    function automatic res_t model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                   input logic icin, input logic isub);
        res_t   r;
        longint mask, aa, bb, sum, am, bm, sm;
        mask   = (longint'(1) << w) - 1;
        aa     = longint'(ia) & mask;
        bb     = isub ? ((~longint'(ib)) & mask) : (longint'(ib) & mask);
        sum    = aa + bb + (isub ? 1 : (icin ? 1 : 0));
        r.s    = 16'(sum & mask);
        r.cout = ((sum >> w) & 1) != 0;
        am     = (aa >> (w - 1)) & 1;
        bm     = (bb >> (w - 1)) & 1;
        sm     = ((sum & mask) >> (w - 1)) & 1;
        r.ovf  = (am == bm) && (sm != am);
        return r;
    endfunction

    // Launch one operation on all instances and wait for u0's done.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, input logic isub, output int lat);
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done0 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (s0 !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h expected 0000", s0); end
        checks++; if ({cout0, ovf0} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {cout0, ovf0}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL add_busy_in_done: got %b expected 0", busy0); end
        checks++; if (s0 !== 16'h5555) begin errors++; $display("FAIL add_s: got %h expected 5555", s0); end
        checks++; if ({cout0, ovf0} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {cout0, ovf0}); end
        @(posedge clk); #1;
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL add_done_width: got %b expected 0", done0); end
        checks++; if (s0 !== 16'h5555) begin errors++; $display("FAIL add_s_hold: got %h expected 5555", s0); end
    endtask

    task automatic test_carry_ovf();
        logic [15:0] va [2] = '{16'hFFFF, 16'h7FFF};
        logic [15:0] es [2] = '{16'h0000, 16'h8000};
        logic [1:0]  ef [2] = '{2'b10, 2'b01};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], 16'h0001, 1'b0, 1'b0, lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL cov_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (s0 !== es[i]) begin errors++; $display("FAIL cov_s[%0d]: got %h expected %h", i, s0, es[i]); end
            checks++; if ({cout0, ovf0} !== ef[i]) begin errors++; $display("FAIL cov_flags[%0d]: got %b expected %b", i, {cout0, ovf0}, ef[i]); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [2] = '{16'h0005, 16'h8000};
        logic [15:0] vb [2] = '{16'h0007, 16'h0001};
        logic [15:0] es [2] = '{16'hFFFE, 16'h7FFF};
        logic [1:0]  ef [2] = '{2'b00, 2'b11};
        int lat;
        for (int i = 0; i < 2; i++) begin
            // cin deliberately set to 0 to show it is ignored in sub mode
            run_op(va[i], vb[i], 1'b0, 1'b1, lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (s0 !== es[i]) begin errors++; $display("FAIL sub_s[%0d]: got %h expected %h", i, s0, es[i]); end
            checks++; if ({cout0, ovf0} !== ef[i]) begin errors++; $display("FAIL sub_flags[%0d]: got %b expected %b", i, {cout0, ovf0}, ef[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen_done;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_run_done: got %b expected 0", done0); end
        checks++; if (s0 !== 16'h0000) begin errors++; $display("FAIL rst_run_s: got %h expected 0000", s0); end
        checks++; if ({cout0, ovf0} !== 2'b00) begin errors++; $display("FAIL rst_run_flags: got %b expected 00", {cout0, ovf0}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1 || busy0 === 1'b1) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL rst_run_no_done: got %0d active cycles expected 0", seen_done); end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL rst_after_latency: got %0d expected 4", lat); end
        checks++; if (s0 !== 16'h1010) begin errors++; $display("FAIL rst_after_s: got %h expected 1010", s0); end
        checks++; if ({cout0, ovf0} !== 2'b00) begin errors++; $display("FAIL rst_after_flags: got %b expected 00", {cout0, ovf0}); end
    endtask

    task automatic test_start_in_run();
        int lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        // second RUN cycle: present a different request that must be ignored
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (done0 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL sir_latency: got %0d expected 4", lat); end
        checks++; if (s0 !== 16'h3333) begin errors++; $display("FAIL sir_s: got %h expected 3333", s0); end
        checks++; if ({cout0, ovf0} !== 2'b00) begin errors++; $display("FAIL sir_flags: got %b expected 00", {cout0, ovf0}); end
        @(posedge clk); #1;
        checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL sir_idle_after: got %b expected 00", {busy0, done0}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (s0 !== 16'h0100) begin errors++; $display("FAIL b2b_first_s: got %h expected 0100", s0); end
        // still inside the DONE cycle: request the next operation now
        a = 16'h1000; b = 16'h0001; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({busy0, done0} !== 2'b10) begin errors++; $display("FAIL b2b_no_gap: got busy,done=%b expected 10", {busy0, done0}); end
        lat = 0;
        while (done0 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        checks++; if (s0 !== 16'h0FFF) begin errors++; $display("FAIL b2b_s: got %h expected 0fff", s0); end
        checks++; if ({cout0, ovf0} !== 2'b10) begin errors++; $display("FAIL b2b_flags: got %b expected 10", {cout0, ovf0}); end
        @(posedge clk); #1;
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b expected 0", done0); end
    endtask

    task automatic test_param_sweep();
        int          widths [4] = '{16, 16, 16, 8};
        int          steps  [4] = '{4, 16, 1, 4};
        int          lat    [4];
        res_t        r;
        logic [15:0] ia, ib;
        logic        ic, isub;
        int          cyc;
        repeat (20) @(posedge clk);
        for (int n = 0; n < 1000; n++) begin
            ia = 16'($urandom); ib = 16'($urandom);
            ic = 1'($urandom);  isub = 1'($urandom);
            @(negedge clk);
            a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = '{-1, -1, -1, -1};
            cyc = 0;
            while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
                for (int k = 0; k < 4; k++)
                    if (done_all[k] === 1'b1 && lat[k] < 0) lat[k] = cyc;
            end
            for (int k = 0; k < 4; k++) begin
                r = model(widths[k], ia, ib, ic, isub);
                checks++; if (lat[k] != steps[k]) begin errors++; $display("FAIL sweep%0d_latency op%0d: got %0d expected %0d", k, n, lat[k], steps[k]); end
                checks++; if (s_all[k] !== r.s) begin errors++; $display("FAIL sweep%0d_s op%0d a=%h b=%h cin=%b sub=%b: got %h expected %h", k, n, ia, ib, ic, isub, s_all[k], r.s); end
                checks++; if (cout_all[k] !== r.cout) begin errors++; $display("FAIL sweep%0d_cout op%0d: got %b expected %b", k, n, cout_all[k], r.cout); end
                checks++; if (ovf_all[k] !== r.ovf) begin errors++; $display("FAIL sweep%0d_ovf op%0d: got %b expected %b", k, n, ovf_all[k], r.ovf); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_ovf();
        test_sub();
        test_reset_mid_run();
        test_start_in_run();
        test_back_to_back();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
